// File: rtl/csync_pkg.sv
// Shared timing constants and lock-edge classification for the composite-sync generator.
// PAL values are the defaults; NTSC values are provided for alternate builds.
package csync_pkg;

  localparam int unsigned PAL_DOTS_PER_LINE   = 766;
  localparam int unsigned PAL_LINES_PER_FRAME = 312;
  localparam int unsigned PAL_VPULSE_DOT      = 100;
  localparam int unsigned PAL_HS_START        = 706;
  localparam int unsigned PAL_HS_LEN          = 60;
  localparam int unsigned PAL_VS_LINE         = 310;

  localparam int unsigned NTSC_DOTS_PER_LINE   = 756;
  localparam int unsigned NTSC_LINES_PER_FRAME = 262;
  localparam int unsigned NTSC_VS_LINE         = 259;

  localparam bit          DEF_VS_POL      = 1'b1;
  localparam int unsigned DEF_LOCK_TOL    = 2;
  localparam int unsigned DEF_LOCK_FRAMES = 4;

  typedef enum logic [1:0] {
    EdgeNone,
    EdgeGood,
    EdgeBad
  } edge_class_e;

  function automatic edge_class_e classify_edge(input logic vs_edge, input logic in_window);
    if (!vs_edge) return EdgeNone;
    return in_window ? EdgeGood : EdgeBad;
  endfunction

endpackage

// File: rtl/csync_frame_gen_if.sv
// Video-side signal bundle of the composite-sync generator.
// master = generator (takes vsync, drives sync/position); slave = source/consumer side.
interface csync_frame_gen_if #(
  parameter int unsigned LINE_W = 9,
  parameter int unsigned DOT_W  = 10
);
  logic              vsync;
  logic              csync;
  logic              locked;
  logic              sof;
  logic [LINE_W-1:0] line;
  logic [DOT_W-1:0]  dot;

  modport master (input vsync, output csync, locked, sof, line, dot);
  modport slave  (output vsync, input csync, locked, sof, line, dot);
endinterface

// File: rtl/vsync_edge_det.sv
// Polarity-normalises the asynchronous vsync, synchronises it and flags its active edge.
// All flops reset to the inactive level so reset release never produces an edge.
module vsync_edge_det #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic vs_edge
);

  logic s0_q, s1_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s0_q   <= vsync ^ ~VS_POL;
      s1_q   <= s0_q;
      prev_q <= s1_q;
    end
  end

  assign vs_edge = s1_q & ~prev_q;

endmodule

// File: rtl/csync_frame_gen.sv
// Composite-sync generator: vsync-realigned dot/line counters, serrated vsync and lock detect.
// Optional CSYNC_EQ_PULSE_EN replaces hsync with two equalising pulses around vertical sync.
module csync_frame_gen
  import csync_pkg::*;
#(
  parameter int unsigned DOTS_PER_LINE   = PAL_DOTS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = PAL_LINES_PER_FRAME,
  parameter int unsigned VPULSE_DOT      = PAL_VPULSE_DOT,
  parameter int unsigned HS_START        = PAL_HS_START,
  parameter int unsigned HS_LEN          = PAL_HS_LEN,
  parameter int unsigned VS_LINE         = PAL_VS_LINE,
  parameter bit          VS_POL          = DEF_VS_POL,
  parameter int unsigned LOCK_TOL        = DEF_LOCK_TOL,
  parameter int unsigned LOCK_FRAMES     = DEF_LOCK_FRAMES
) (
  input logic              clk,
  input logic              rst,
  csync_frame_gen_if.master bus
);

  localparam int unsigned LINE_W = $clog2(LINES_PER_FRAME);
  localparam int unsigned DOT_W  = $clog2(DOTS_PER_LINE);
  localparam int unsigned CNT_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [DOT_W-1:0]  DotLast    = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0]  DotVpulse  = DOT_W'(VPULSE_DOT);
  localparam logic [DOT_W-1:0]  DotSerr    = DOT_W'(HS_START - HS_LEN);
  localparam logic [DOT_W-1:0]  DotHs      = DOT_W'(HS_START);
  localparam logic [LINE_W-1:0] LineLast   = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [LINE_W-1:0] LineVs     = LINE_W'(VS_LINE);
  localparam logic [LINE_W-1:0] LineWinLo  = LINE_W'(LINES_PER_FRAME - LOCK_TOL);
  localparam logic [LINE_W-1:0] LineWinHi  = LINE_W'(LOCK_TOL);
  localparam logic [CNT_W-1:0]  CntMax     = CNT_W'(LOCK_FRAMES);

  if (HS_START + HS_LEN > DOTS_PER_LINE) begin : g_chk_hs_end
    $error("HS_START + HS_LEN exceeds DOTS_PER_LINE");
  end
  if (HS_LEN > HS_START) begin : g_chk_hs_len
    $error("HS_LEN exceeds HS_START");
  end
  if (VS_LINE >= LINES_PER_FRAME) begin : g_chk_vs_line
    $error("VS_LINE must be below LINES_PER_FRAME");
  end
  if (VPULSE_DOT >= DOTS_PER_LINE) begin : g_chk_vpulse
    $error("VPULSE_DOT must be below DOTS_PER_LINE");
  end

  logic              vs_edge;
  logic [DOT_W-1:0]  dot_q, dot_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic              sof_q, sof_d;
  logic              locked_q, locked_d;
  logic              csync_q, csync_d;
  logic              line_step;
  edge_class_e       edge_cls;

  vsync_edge_det #(
    .VS_POL(VS_POL)
  ) u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .vsync  (bus.vsync),
    .vs_edge(vs_edge)
  );

  // Good window straddles the frame boundary: last LOCK_TOL lines or first LOCK_TOL lines.
  assign edge_cls = classify_edge(vs_edge, (line_q >= LineWinLo) || (line_q < LineWinHi));

  always_comb begin
    dot_d     = dot_q;
    line_d    = line_q;
    sof_d     = 1'b0;
    line_step = 1'b0;
    if (vs_edge) begin
      line_d = '0;
      dot_d  = DotVpulse;
    end else if (dot_q == DotLast) begin
      dot_d = '0;
      if (line_q == LineLast) begin
        line_d = '0;
        sof_d  = 1'b1;
      end else begin
        line_d    = line_q + 1'b1;
        line_step = 1'b1;
      end
    end else begin
      dot_d = dot_q + 1'b1;
    end
  end

  always_comb begin
    seen_d = seen_q;
    cnt_d  = cnt_q;
    case (edge_cls)
      EdgeGood: begin
        seen_d = 1'b1;
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      end
      EdgeBad: cnt_d = '0;
      default: ;
    endcase
    if (line_step && (line_d == LineWinLo)) seen_d = 1'b0;
    // Stepping out of the early window without having seen vsync is a missed frame.
    if (line_step && (line_d == LineWinHi) && !seen_q) cnt_d = '0;
    locked_d = (cnt_d == CntMax);
  end

  logic in_serr, in_hsync, in_vregion;
  assign in_serr    = (dot_q >= DotSerr) && (dot_q < DotHs);
  assign in_hsync   = (dot_q >= DotHs);
  assign in_vregion = (line_q >= LineVs);

`ifdef CSYNC_EQ_PULSE_EN
  localparam int unsigned EqLoLine = (VS_LINE >= 3) ? VS_LINE - 3 : 0;
  localparam logic [LINE_W-1:0] LineEqLo  = LINE_W'(EqLoLine);
  localparam logic [LINE_W-1:0] LineEqHi  = LINE_W'(3);
  localparam logic [DOT_W-1:0]  DotEq1End = DOT_W'(HS_START + HS_LEN / 2);
  localparam logic [DOT_W-1:0]  DotEq2    = DOT_W'((HS_START + DOTS_PER_LINE / 2) % DOTS_PER_LINE);
  localparam logic [DOT_W-1:0]  DotWrap   = DOT_W'(DOTS_PER_LINE);
  localparam logic [DOT_W-1:0]  DotEqHalf = DOT_W'(HS_LEN / 2);

  logic             eq_line, eq_pulse;
  logic [DOT_W-1:0] eq2_off;

  assign eq_line  = ((line_q >= LineEqLo) && (line_q < LineVs)) || (line_q < LineEqHi);
  // Mid-line pulse may start late in the line, so measure its offset modulo the line length.
  assign eq2_off  = (dot_q >= DotEq2) ? dot_q - DotEq2 : dot_q + DotWrap - DotEq2;
  assign eq_pulse = ((dot_q >= DotHs) && (dot_q < DotEq1End)) || (eq2_off < DotEqHalf);
`endif

  always_comb begin
    csync_d = 1'b1;
    if (in_serr) begin
      csync_d = 1'b1;
`ifdef CSYNC_EQ_PULSE_EN
    end else if (eq_line) begin
      csync_d = ~eq_pulse;
`endif
    end else if (in_hsync || in_vregion) begin
      csync_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_q    <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      sof_q    <= 1'b0;
      locked_q <= 1'b0;
      csync_q  <= 1'b1;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      sof_q    <= sof_d;
      locked_q <= locked_d;
      csync_q  <= csync_d;
    end
  end

  assign bus.dot    = dot_q;
  assign bus.line   = line_q;
  assign bus.sof    = sof_q;
  assign bus.locked = locked_q;
  assign bus.csync  = csync_q;

endmodule

// File: doc/csync_frame_gen.md
Name: csync_frame_gen

Overview:
Parametrised composite-sync generator for Atari video capture/conversion paths. Free-running dot/line counters are re-aligned on every detected vsync edge, and the block emits composite sync with serrated vertical sync. When vsync disappears it falls back to a self-timed frame. A lock detector reports whether incoming vsync arrives where a frame should end, and the current dot/line position is exported for downstream timing.

Parameters:
DOTS_PER_LINE, 766, dots per line; dot counter wraps at DOTS_PER_LINE-1
LINES_PER_FRAME, 312, lines per free-running frame; line counter wraps at LINES_PER_FRAME-1
VPULSE_DOT, 100, dot value loaded on a detected vsync edge
HS_START, 706, first dot of horizontal sync low
HS_LEN, 60, horizontal sync width in dots; serration high window is HS_START-HS_LEN .. HS_START-1
VS_LINE, 310, first vertical-sync line; vertical region is VS_LINE .. frame end
VS_POL, 1, active vsync polarity (1 = rising edge is the event)
LOCK_TOL, 2, tolerance in lines either side of the frame boundary
LOCK_FRAMES, 4, consecutive good frames needed to assert locked

Ports:
clk  in  1  dot clock
rst  in  1  asynchronous, active-high reset
vsync  in  1  asynchronous vsync from source
csync  out  1  registered composite sync, active low
locked  out  1  vsync lock status
sof  out  1  one-cycle pulse on the cycle line and dot both load 0
line  out  LINE_W  current line counter; LINE_W = $clog2(LINES_PER_FRAME)
dot  out  DOT_W  current dot counter; DOT_W = $clog2(DOTS_PER_LINE)

Behaviour:
- Reset: dot=0, line=0, csync=1, locked=0, sof=0, lock counter=0, seen=0. Sync flops preset to the inactive level, so no edge is detected out of reset.
- Input path: vsync XOR ~VS_POL -> s0 -> s1 -> prev. Edge = s1 & ~prev. Edge is seen by the counters 3 clk after the input transition.
- Counter priority, per clk:
  1. On edge: line<=0, dot<=VPULSE_DOT.
  2. Else if dot==DOTS_PER_LINE-1: dot<=0. If line==LINES_PER_FRAME-1, line<=0 (free-run wrap); else line<=line+1.
  3. Else dot<=dot+1.
- sof is asserted when line and dot both load 0 (free-run wrap only; an edge loads dot=VPULSE_DOT).
- csync is registered and reflects the counters of the previous cycle:
  - dot in [HS_START-HS_LEN, HS_START-1]: csync=1 (serration high, also in the vertical region).
  - else dot >= HS_START: csync=0 (hsync).
  - else line >= VS_LINE: csync=0 (vertical sync).
  - else csync=1.
- Lock detector:
  - seen clears when line enters LINES_PER_FRAME-LOCK_TOL.
  - Good edge: edge while line >= LINES_PER_FRAME-LOCK_TOL, or while line < LOCK_TOL. Sets seen; lock counter increments, saturating at LOCK_FRAMES.
  - Bad edge: any other edge. Lock counter=0, locked=0.
  - Miss: line transitions LOCK_TOL-1 -> LOCK_TOL with seen=0. Lock counter=0, locked=0.
  - locked=1 while lock counter==LOCK_FRAMES.
- Edge coincident with a line/frame wrap: edge wins.
- Reset mid-frame: all state returns to reset values immediately (asynchronous).
- Parameter legality: HS_START+HS_LEN <= DOTS_PER_LINE, HS_LEN <= HS_START, VS_LINE < LINES_PER_FRAME, VPULSE_DOT < DOTS_PER_LINE. Checked by elaboration-time assertions.

Optional Feature:
CSYNC_EQ_PULSE_EN:
- Defined: on lines VS_LINE-3 .. VS_LINE-1 and 0 .. 2, hsync is replaced by two equalising pulses per line. Each is low for HS_LEN/2 dots, starting at HS_START and at (HS_START + DOTS_PER_LINE/2) mod DOTS_PER_LINE.
- Undefined: those lines carry normal hsync, and the behaviour is exactly as above.

Decomposition:
- Package csync_pkg: default PAL timing constants, plus an NTSC constant set (DOTS_PER_LINE 756, LINES_PER_FRAME 262, VS_LINE 259).
- Sub-module vsync_edge_det: polarity adjust, 2-flop synchroniser and edge register, with reset. Lock logic stays in the top module.

Test Plan:
- Reset, no vsync -> csync=1 first cycle; sof every 766*312 clk; csync low dots 706..765 on lines 0..309; lines 310..311 low except dots 646..705.
- Vsync rise at arbitrary time -> 3 clk later dot=100, line=0; sof not asserted; next line increment at dot 765->0.
- Periodic vsync every 312 lines, aligned -> locked rises on the 4th good edge and holds; no misses.
- Vsync removed after lock -> locked falls when line 1->2 with seen=0; free-run continues with unchanged csync timing.
- Vsync edge at line 150 while locked -> locked=0, lock counter 0; recovery after 4 further good edges.
- With CSYNC_EQ_PULSE_EN, line 308 -> two 30-dot low pulses at dots 706 and 323; without the macro, one 60-dot pulse at 706.
